mlx_frame_reader: RTL and testbench

Sequencer that sits directly downstream of the camera status poll: once the MLX90640 reports a new subpage (status bit 3 set), it drives the byte-level `i2c_controller` to read the 832-word RAM frame from device address 0x33 and streams assembled 16-bit words into the pixel buffer. It then clears the new-data flag in the status register, so the next poll sees only a fresh subpage. It runs on the 800 kHz I2C clock domain that also clocks `i2c_controller`.

---
 rtl/mlx_frame_reader.sv | 127 ++++++++++++
 tb/tb_mlx_frame_reader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mlx_frame_reader.sv
// rtl/mlx_frame_reader.sv - reads one MLX90640 RAM frame over I2C into the pixel buffer, then clears the new-data flag
module mlx_frame_reader #(
  parameter logic [6:0]  DEVICE_ADDR  = 7'h33,
  parameter logic [15:0] RAM_BASE     = 16'h0400,
  parameter int          WORD_COUNT   = 832,
  parameter logic [15:0] STATUS_ADDR  = 16'h8000,
  parameter logic [15:0] STATUS_CLEAR = 16'h0030
) (
  input  logic        clk,
  input  logic        not_reset,
  input  logic        start,
  input  logic        page,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [6:0]  i2c_address,
  output logic        i2c_read_write,
  output logic [7:0]  i2c_transmit_data,
  output logic        i2c_enable_transfer,
  input  logic [7:0]  i2c_received_data,
  input  logic        i2c_idle,
  input  logic        i2c_ack,
  input  logic        i2c_nack,
  output logic        pixel_wr_en,
  output logic [9:0]  pixel_wr_addr,
  output logic [15:0] pixel_wr_data,
  output logic        pixel_wr_page
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADR_HI, S_ADR_LO, S_SW_READ, S_RD_HI, S_RD_LO, S_WRITE, S_END_READ,
    S_CLR_A_HI, S_CLR_A_LO, S_CLR_D_HI, S_CLR_D_LO, S_CLR_STOP, S_DONE, S_ERROR
  } state_t;

  localparam logic [9:0] LAST_INDEX = 10'(WORD_COUNT - 1);

  state_t      state, next_state;
  logic [1:0]  ack_sr, nack_sr;
  logic [9:0]  index;
  logic [7:0]  hi_byte, lo_byte;
  logic        page_q, error_q;
  logic        success, failure, enable, read_write, wr_en, done_pulse;
  logic [7:0]  tx;

  assign success = (ack_sr == 2'b01);
  assign failure = (nack_sr == 2'b01);

  always_comb begin
    next_state = state;
    enable     = 1'b0;
    read_write = 1'b0;
    tx         = 8'h00;
    wr_en      = 1'b0;
    done_pulse = 1'b0;
    case (state)
      S_IDLE:     if (start) next_state = S_ADR_HI;
      S_ADR_HI:   begin enable = 1'b1; tx = RAM_BASE[15:8]; if (success) next_state = S_ADR_LO; end
      S_ADR_LO:   begin enable = 1'b1; tx = RAM_BASE[7:0];  if (success) next_state = S_SW_READ; end
      S_SW_READ:  begin read_write = 1'b1; if (i2c_idle) next_state = S_RD_HI; end
      S_RD_HI:    begin enable = 1'b1; read_write = 1'b1; if (success) next_state = S_RD_LO; end
      S_RD_LO:    begin enable = 1'b1; read_write = 1'b1; if (success) next_state = S_WRITE; end
      S_WRITE: begin
        enable     = 1'b1;
        read_write = 1'b1;
        wr_en      = 1'b1;
        next_state = (index == LAST_INDEX) ? S_END_READ : S_RD_HI;
      end
      S_END_READ: begin read_write = 1'b1; if (i2c_idle) next_state = S_CLR_A_HI; end
      S_CLR_A_HI: begin enable = 1'b1; tx = STATUS_ADDR[15:8];  if (success) next_state = S_CLR_A_LO; end
      S_CLR_A_LO: begin enable = 1'b1; tx = STATUS_ADDR[7:0];   if (success) next_state = S_CLR_D_HI; end
      S_CLR_D_HI: begin enable = 1'b1; tx = STATUS_CLEAR[15:8]; if (success) next_state = S_CLR_D_LO; end
      S_CLR_D_LO: begin enable = 1'b1; tx = STATUS_CLEAR[7:0];  if (success) next_state = S_CLR_STOP; end
      S_CLR_STOP: if (i2c_idle) next_state = S_DONE;
      S_DONE:     begin done_pulse = 1'b1; next_state = S_IDLE; end
      S_ERROR:    if (i2c_idle) next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
    // The master NACK on the final read byte is expected, so it must not abort the frame.
    if (failure && enable && !(state == S_RD_LO && index == LAST_INDEX))
      next_state = S_ERROR;
  end

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state   <= S_IDLE;
      ack_sr  <= 2'b00;
      nack_sr <= 2'b00;
      index   <= 10'd0;
      hi_byte <= 8'h00;
      lo_byte <= 8'h00;
      page_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state   <= next_state;
      ack_sr  <= {ack_sr[0], i2c_ack};
      nack_sr <= {nack_sr[0], i2c_nack};
      if (state == S_IDLE && start) begin
        page_q  <= page;
        error_q <= 1'b0;
        index   <= 10'd0;
      end
      if (state == S_ERROR)
        error_q <= 1'b1;
      if (state == S_SW_READ)
        index <= 10'd0;
      if (state == S_RD_HI && next_state == S_RD_LO)
        hi_byte <= i2c_received_data;
      if (state == S_RD_LO && next_state == S_WRITE)
        lo_byte <= i2c_received_data;
      if (state == S_WRITE && index != LAST_INDEX)
        index <= index + 10'd1;
    end
  end

  assign busy                = (state != S_IDLE);
  assign done                = done_pulse;
  assign error               = error_q;
  assign i2c_address         = DEVICE_ADDR;
  assign i2c_read_write      = read_write;
  assign i2c_transmit_data   = tx;
  assign i2c_enable_transfer = enable;
  assign pixel_wr_en         = wr_en;
  assign pixel_wr_addr       = index;
  assign pixel_wr_data       = {hi_byte, lo_byte};
  assign pixel_wr_page       = page_q;

endmodule

// File: tb/tb_mlx_frame_reader.sv
// tb/tb_mlx_frame_reader.sv - self-checking bench for mlx_frame_reader with a behavioural I2C controller model
module tb_mlx_frame_reader;

  logic        clk = 1'b0;
  logic        not_reset;
  logic        start, page;
  logic        busy, done, error;
  logic [6:0]  i2c_address;
  logic        i2c_read_write, i2c_enable_transfer;
  logic [7:0]  i2c_transmit_data, i2c_received_data;
  logic        i2c_idle, i2c_ack, i2c_nack;
  logic        pixel_wr_en, pixel_wr_page;
  logic [9:0]  pixel_wr_addr;
  logic [15:0] pixel_wr_data;

  mlx_frame_reader dut (
    .clk(clk), .not_reset(not_reset), .start(start), .page(page),
    .busy(busy), .done(done), .error(error),
    .i2c_address(i2c_address), .i2c_read_write(i2c_read_write),
    .i2c_transmit_data(i2c_transmit_data), .i2c_enable_transfer(i2c_enable_transfer),
    .i2c_received_data(i2c_received_data), .i2c_idle(i2c_idle),
    .i2c_ack(i2c_ack), .i2c_nack(i2c_nack),
    .pixel_wr_en(pixel_wr_en), .pixel_wr_addr(pixel_wr_addr),
    .pixel_wr_data(pixel_wr_data), .pixel_wr_page(pixel_wr_page)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
  endtask

  // Controller model: fixed byte times, ack pulse of two cycles, optional injected NACKs.
  int         rbyte_cnt = 0;
  int         wbyte_cnt = 0;
  int         nack_wbyte = -1;
  int         both_rbyte = -1;
  logic [7:0] tx_log[$];

  initial begin
    logic rw, active, give_ack, give_nack;
    i2c_idle = 1'b1; i2c_ack = 1'b0; i2c_nack = 1'b0; i2c_received_data = 8'h00;
    forever begin
      @(negedge clk);
      if (i2c_enable_transfer) begin
        rw = i2c_read_write;
        i2c_idle = 1'b0;
        active = 1'b1;
        while (active) begin
          repeat ($urandom_range(3, 5)) @(negedge clk);
          if (!i2c_enable_transfer) begin
            active = 1'b0;
          end else begin
            give_ack = 1'b1;
            give_nack = 1'b0;
            if (rw) begin
              i2c_received_data = rbyte_cnt[7:0];
              if (rbyte_cnt == both_rbyte) give_nack = 1'b1;
              rbyte_cnt++;
            end else begin
              tx_log.push_back(i2c_transmit_data);
              if (wbyte_cnt == nack_wbyte) begin give_nack = 1'b1; give_ack = 1'b0; end
              wbyte_cnt++;
            end
            i2c_ack = give_ack;
            i2c_nack = give_nack;
            repeat (2) @(negedge clk);
            i2c_ack = 1'b0;
            i2c_nack = 1'b0;
          end
        end
        repeat ($urandom_range(1, 4)) @(negedge clk);
        i2c_idle = 1'b1;
      end
    end
  end

  // Scoreboard: word n must carry bytes 2n and 2n+1 of the read stream.
  int   strobe_cnt = 0;
  int   done_cnt = 0;
  logic exp_page = 1'b0;
  logic prev_wr = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (pixel_wr_en) begin
      check("wr_addr", 32'(pixel_wr_addr), strobe_cnt);
      check("wr_data", 32'(pixel_wr_data), {16'h0, 8'(2 * strobe_cnt), 8'(2 * strobe_cnt + 1)});
      check("wr_page", 32'(pixel_wr_page), 32'(exp_page));
      check("wr_gap", 32'(prev_wr), 0);
      strobe_cnt++;
    end
    if (prev_done) check("busy_after_done", 32'(busy), 0);
    if (done) done_cnt++;
    prev_wr = pixel_wr_en;
    prev_done = done;
  end

  task automatic launch(input logic pg);
    int n = 0;
    while (!i2c_idle && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    check("busy_pre", 32'(busy), 0);
    start = 1'b1;
    page = pg;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", 32'(busy), 1);
    check("error_clr", 32'(error), 0);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin @(negedge clk); n++; end
    check("run_timeout", 32'(busy), 0);
  endtask

  task automatic prep(input logic pg, input int nw, input int br);
    nack_wbyte = nw;
    both_rbyte = br;
    rbyte_cnt = 0;
    wbyte_cnt = 0;
    tx_log.delete();
    strobe_cnt = 0;
    done_cnt = 0;
    exp_page = pg;
  endtask

  typedef struct {
    logic page;
    int   nack_w;
    int   both_r;
    int   exp_strobes;
    int   exp_done;
    logic exp_err;
    int   exp_ntx;
    int   exp_nrd;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] exp_tx[6];

  initial begin
    int n;
    exp_tx = '{8'h04, 8'h00, 8'h80, 8'h00, 8'h00, 8'h30};
    vecs[0] = '{1'b1, -1, -1, 832, 1, 1'b0, 6, 1664};
    vecs[1] = '{1'b0,  1, -1,   0, 0, 1'b1, 2,    0};
    vecs[2] = '{1'($urandom_range(0, 1)), -1, -1, 832, 1, 1'b0, 6, 1664};
    vecs[3] = '{1'b1,  4, -1, 832, 0, 1'b1, 5, 1664};
    vecs[4] = '{1'b0, -1, 10,   5, 0, 1'b1, 2,   11};

    not_reset = 1'b0;
    start = 1'b0;
    page = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_en", 32'(i2c_enable_transfer), 0);
    check("rst_wr_data", 32'(pixel_wr_data), 0);
    check("rst_addr", 32'(i2c_address), 32'h33);
    not_reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      prep(vecs[i].page, vecs[i].nack_w, vecs[i].both_r);
      launch(vecs[i].page);
      wait_idle(20000);
      repeat (2) @(negedge clk);
      check("strobes", strobe_cnt, vecs[i].exp_strobes);
      check("done_cnt", done_cnt, vecs[i].exp_done);
      check("error", 32'(error), 32'(vecs[i].exp_err));
      check("enable_off", 32'(i2c_enable_transfer), 0);
      check("tx_count", tx_log.size(), vecs[i].exp_ntx);
      check("rd_count", rbyte_cnt, vecs[i].exp_nrd);
      for (int k = 0; k < tx_log.size() && k < 6; k++)
        check("tx_byte", 32'(tx_log[k]), 32'(exp_tx[k]));
    end

    // Asynchronous reset while the low byte of word 400 is outstanding.
    prep(1'b1, -1, -1);
    launch(1'b1);
    n = 0;
    while (rbyte_cnt < 801 && n < 20000) begin @(negedge clk); n++; end
    check("reach_word400", rbyte_cnt, 801);
    repeat (3) @(negedge clk);
    not_reset = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_en", 32'(i2c_enable_transfer), 0);
    check("arst_rw", 32'(i2c_read_write), 0);
    check("arst_wr_en", 32'(pixel_wr_en), 0);
    check("arst_wr_addr", 32'(pixel_wr_addr), 0);
    check("arst_wr_data", 32'(pixel_wr_data), 0);
    check("arst_wr_page", 32'(pixel_wr_page), 0);
    check("arst_addr", 32'(i2c_address), 32'h33);
    repeat (3) @(negedge clk);
    not_reset = 1'b1;
    repeat (30) @(negedge clk);
    check("no_strobes_after_rst", strobe_cnt, 400);
    check("idle_after_rst", 32'(busy), 0);

    // Restart from word 0, and a start with page 0 mid-frame must be ignored.
    prep(1'b1, -1, -1);
    launch(1'b1);
    n = 0;
    while (strobe_cnt < 10 && n < 20000) begin @(negedge clk); n++; end
    @(negedge clk);
    start = 1'b1;
    page = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_hold", 32'(busy), 1);
    check("page_hold", 32'(pixel_wr_page), 1);
    check("error_hold", 32'(error), 0);
    wait_idle(20000);
    repeat (2) @(negedge clk);
    check("restart_strobes", strobe_cnt, 832);
    check("restart_done", done_cnt, 1);
    check("restart_error", 32'(error), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
